// File: rtl/flag_pkg.sv
// ---------------------------------------------------------------------------
// flag_pkg
// Shared types for the ALU status-flag consumer logic.
//   flags_t   : architectural NZCV flags, packed {n,z,c,v} (n is the MSB)
//   br_kind_e : branch request type (B, B.cond, CBZ, CBNZ)
//   cond_e    : the 16 LEGv8 condition codes
//   state_e   : decision FSM states
// ---------------------------------------------------------------------------
package flag_pkg;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic [1:0] {
    BR_B     = 2'd0,
    BR_BCOND = 2'd1,
    BR_CBZ   = 2'd2,
    BR_CBNZ  = 2'd3
  } br_kind_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_HS = 4'h2,
    COND_LO = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_RESOLVE = 1'b1
  } state_e;

endpackage : flag_pkg

// File: rtl/cond_eval.sv
// ---------------------------------------------------------------------------
// cond_eval
// Purely combinational LEGv8 condition-code evaluator. Reusable by any
// consumer of NZCV (branches, conditional select).
//   flags_i  : effective NZCV flags
//   cond_i   : condition code
//   result_o : 1 when the condition holds
// ---------------------------------------------------------------------------
module cond_eval
  import flag_pkg::*;
(
  input  flags_t flags_i,
  input  cond_e  cond_i,
  output logic   result_o
);

  logic n_eq_v;
  logic hi;
  logic gt;

  always_comb begin
    n_eq_v   = (flags_i.n == flags_i.v);
    hi       = flags_i.c & ~flags_i.z;
    gt       = ~flags_i.z & n_eq_v;
    result_o = 1'b0;
    unique case (cond_i)
      COND_EQ: result_o =  flags_i.z;
      COND_NE: result_o = ~flags_i.z;
      COND_HS: result_o =  flags_i.c;
      COND_LO: result_o = ~flags_i.c;
      COND_MI: result_o =  flags_i.n;
      COND_PL: result_o = ~flags_i.n;
      COND_VS: result_o =  flags_i.v;
      COND_VC: result_o = ~flags_i.v;
      COND_HI: result_o =  hi;
      COND_LS: result_o = ~hi;
      COND_GE: result_o =  n_eq_v;
      COND_LT: result_o = ~n_eq_v;
      COND_GT: result_o =  gt;
      COND_LE: result_o = ~gt;
      COND_AL: result_o = 1'b1;
      COND_NV: result_o = 1'b1;
      default: result_o = 1'b0;
    endcase
  end

endmodule : cond_eval

// File: rtl/branch_flag_unit.sv
// ---------------------------------------------------------------------------
// branch_flag_unit
// Latches ALU NZCV into the architectural flag register and resolves LEGv8
// branches (B, B.cond, CBZ, CBNZ), returning one registered decision per
// request one cycle later.
//   clk, reset_n       : clock, asynchronous active-low reset
//   alu_negative/zero/carry/overflow : live ALU flags
//   set_flags          : current instruction writes NZCV
//   br_valid, br_kind, br_cond : branch request
//   flush              : squash the request of this cycle
//   flags              : architectural {N,Z,C,V}
//   br_done, br_taken  : decision pulse and result
// ---------------------------------------------------------------------------
module branch_flag_unit
  import flag_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       alu_negative,
  input  logic       alu_zero,
  input  logic       alu_carry,
  input  logic       alu_overflow,
  input  logic       set_flags,
  input  logic       br_valid,
  input  logic [1:0] br_kind,
  input  logic [3:0] br_cond,
  input  logic       flush,
  output logic [3:0] flags,
  output logic       br_done,
  output logic       br_taken
);

  // WIDTH only documents the ALU bus; zero detection arrives precomputed.
  if (WIDTH == 0) begin : g_width_unused
  end

  flags_t alu_flags;
  flags_t eff_flags;
  flags_t flags_d, flags_q;
  state_e state_d, state_q;
  logic   br_done_d, br_done_q;
  logic   br_taken_d, br_taken_q;
  logic   cond_true;
  logic   decision;
  logic   accept;

  cond_eval u_cond_eval (
    .flags_i  (eff_flags),
    .cond_i   (cond_e'(br_cond)),
    .result_o (cond_true)
  );

  always_comb begin
    alu_flags = '{n: alu_negative, z: alu_zero, c: alu_carry, v: alu_overflow};

    // Flag write is independent of flush.
    flags_d = flags_q;
    if (set_flags) flags_d = alu_flags;

    // Same-cycle flag writes are forwarded to the branch being evaluated.
    eff_flags = set_flags ? alu_flags : flags_q;

    decision = 1'b0;
    unique case (br_kind_e'(br_kind))
      BR_B:     decision = 1'b1;
      BR_BCOND: decision = cond_true;
      BR_CBZ:   decision = alu_zero;
      BR_CBNZ:  decision = ~alu_zero;
      default:  decision = 1'b0;
    endcase

    accept  = br_valid & ~flush;
    state_d = S_IDLE;
    unique case (state_q)
      S_IDLE:    state_d = accept ? S_RESOLVE : S_IDLE;
      S_RESOLVE: state_d = accept ? S_RESOLVE : S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    br_done_d  = (state_d == S_RESOLVE);
    br_taken_d = (state_d == S_RESOLVE) & decision;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q    <= '0;
      state_q    <= S_IDLE;
      br_done_q  <= 1'b0;
      br_taken_q <= 1'b0;
    end else begin
      flags_q    <= flags_d;
      state_q    <= state_d;
      br_done_q  <= br_done_d;
      br_taken_q <= br_taken_d;
    end
  end

  assign flags    = flags_q;
  assign br_done  = br_done_q;
  assign br_taken = br_taken_q;

endmodule : branch_flag_unit

// File: tb/tb_branch_flag_unit.sv
module tb_branch_flag_unit;

  logic       clk;
  logic       reset_n;
  logic       alu_negative, alu_zero, alu_carry, alu_overflow;
  logic       set_flags;
  logic       br_valid;
  logic [1:0] br_kind;
  logic [3:0] br_cond;
  logic       flush;
  logic [3:0] flags;
  logic       br_done;
  logic       br_taken;

  int errors = 0;
  int checks = 0;

  branch_flag_unit #(.WIDTH(64)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .alu_negative (alu_negative),
    .alu_zero     (alu_zero),
    .alu_carry    (alu_carry),
    .alu_overflow (alu_overflow),
    .set_flags    (set_flags),
    .br_valid     (br_valid),
    .br_kind      (br_kind),
    .br_cond      (br_cond),
    .flush        (flush),
    .flags        (flags),
    .br_done      (br_done),
    .br_taken     (br_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       set_flags;
    logic [3:0] alu;      // {N,Z,C,V}
    logic       br_valid;
    logic [1:0] kind;
    logic [3:0] cond;
    logic       flush;
    logic [3:0] exp_flags;
    logic       exp_done;
    logic       exp_taken;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic sf, logic [3:0] alu, logic bv,
                              logic [1:0] kind, logic [3:0] cond, logic fl,
                              logic [3:0] ef, logic ed, logic et);
    vec_t v;
    v.name = name; v.set_flags = sf; v.alu = alu; v.br_valid = bv;
    v.kind = kind; v.cond = cond; v.flush = fl;
    v.exp_flags = ef; v.exp_done = ed; v.exp_taken = et;
    return v;
  endfunction

  task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    set_flags = 1'b0; br_valid = 1'b0; br_kind = 2'd0; br_cond = 4'h0; flush = 1'b0;
    {alu_negative, alu_zero, alu_carry, alu_overflow} = 4'b0000;
  endtask

  initial begin
    drive_idle();
    reset_n = 1'b0;
    #2;
    chk("reset_flags", flags, 4'b0000);
    chk("reset_done", {3'b0, br_done}, 4'd0);
    chk("reset_taken", {3'b0, br_taken}, 4'd0);
    #20;
    reset_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("idle_done", {3'b0, br_done}, 4'd0);
      chk("idle_flags", flags, 4'b0000);
    end

    // kind: 0 B, 1 B.cond, 2 CBZ, 3 CBNZ; rows run back-to-back.
    vecs.push_back(mk("nop",        0, 4'b0000, 0, 2'd0, 4'h0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk("set_N",      1, 4'b1000, 0, 2'd0, 4'h0, 0, 4'b1000, 0, 0));
    vecs.push_back(mk("lt_N1V0",    0, 4'b0000, 1, 2'd1, 4'hB, 0, 4'b1000, 1, 1));
    vecs.push_back(mk("ge_N1V0",    0, 4'b0000, 1, 2'd1, 4'hA, 0, 4'b1000, 1, 0));
    vecs.push_back(mk("gap",        0, 4'b0000, 0, 2'd0, 4'h0, 0, 4'b1000, 0, 0));
    vecs.push_back(mk("fwd_eq",     1, 4'b0100, 1, 2'd1, 4'h0, 0, 4'b0100, 1, 1));
    vecs.push_back(mk("clr_flags",  1, 4'b0000, 0, 2'd0, 4'h0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk("cbz_live1",  0, 4'b0100, 1, 2'd2, 4'h0, 0, 4'b0000, 1, 1));
    vecs.push_back(mk("cbnz_live1", 0, 4'b0100, 1, 2'd3, 4'h0, 0, 4'b0000, 1, 0));
    vecs.push_back(mk("cbnz_live0", 0, 4'b0000, 1, 2'd3, 4'h0, 0, 4'b0000, 1, 1));
    vecs.push_back(mk("cbz_live0",  0, 4'b0000, 1, 2'd2, 4'h0, 0, 4'b0000, 1, 0));
    vecs.push_back(mk("b_uncond",   0, 4'b0000, 1, 2'd0, 4'h1, 0, 4'b0000, 1, 1));
    vecs.push_back(mk("al_e",       0, 4'b0000, 1, 2'd1, 4'hE, 0, 4'b0000, 1, 1));
    vecs.push_back(mk("al_f",       0, 4'b0000, 1, 2'd1, 4'hF, 0, 4'b0000, 1, 1));
    vecs.push_back(mk("set_C",      1, 4'b0010, 0, 2'd0, 4'h0, 0, 4'b0010, 0, 0));
    vecs.push_back(mk("hi",         0, 4'b0000, 1, 2'd1, 4'h8, 0, 4'b0010, 1, 1));
    vecs.push_back(mk("ls",         0, 4'b0000, 1, 2'd1, 4'h9, 0, 4'b0010, 1, 0));
    vecs.push_back(mk("flush_req",  0, 4'b0000, 1, 2'd0, 4'h0, 1, 4'b0010, 0, 0));
    vecs.push_back(mk("flush_set",  1, 4'b1001, 0, 2'd0, 4'h0, 1, 4'b1001, 0, 0));
    vecs.push_back(mk("gt_N1V1",    0, 4'b0000, 1, 2'd1, 4'hC, 0, 4'b1001, 1, 1));
    vecs.push_back(mk("le_N1V1",    0, 4'b0000, 1, 2'd1, 4'hD, 0, 4'b1001, 1, 0));
    vecs.push_back(mk("mi",         0, 4'b0000, 1, 2'd1, 4'h4, 0, 4'b1001, 1, 1));
    vecs.push_back(mk("pl",         0, 4'b0000, 1, 2'd1, 4'h5, 0, 4'b1001, 1, 0));
    vecs.push_back(mk("vs",         0, 4'b0000, 1, 2'd1, 4'h6, 0, 4'b1001, 1, 1));
    vecs.push_back(mk("vc",         0, 4'b0000, 1, 2'd1, 4'h7, 0, 4'b1001, 1, 0));
    vecs.push_back(mk("ne",         0, 4'b0000, 1, 2'd1, 4'h1, 0, 4'b1001, 1, 1));
    vecs.push_back(mk("hs",         0, 4'b0000, 1, 2'd1, 4'h2, 0, 4'b1001, 1, 0));
    vecs.push_back(mk("lo",         0, 4'b0000, 1, 2'd1, 4'h3, 0, 4'b1001, 1, 1));
    vecs.push_back(mk("eq_z0",      0, 4'b0000, 1, 2'd1, 4'h0, 0, 4'b1001, 1, 0));
    vecs.push_back(mk("fwd_mi",     1, 4'b0001, 1, 2'd1, 4'h4, 0, 4'b0001, 1, 0));
    vecs.push_back(mk("flush_bcnd", 0, 4'b0000, 1, 2'd1, 4'hE, 1, 4'b0001, 0, 0));

    foreach (vecs[i]) begin
      set_flags = vecs[i].set_flags;
      {alu_negative, alu_zero, alu_carry, alu_overflow} = vecs[i].alu;
      br_valid  = vecs[i].br_valid;
      br_kind   = vecs[i].kind;
      br_cond   = vecs[i].cond;
      flush     = vecs[i].flush;
      @(posedge clk); #1;
      chk({vecs[i].name, "_flags"}, flags, vecs[i].exp_flags);
      chk({vecs[i].name, "_done"},  {3'b0, br_done},  {3'b0, vecs[i].exp_done});
      chk({vecs[i].name, "_taken"}, {3'b0, br_taken}, {3'b0, vecs[i].exp_taken});
    end

    // Reset in the middle of a RESOLVE pulse cuts it without waiting for a clock.
    drive_idle();
    set_flags = 1'b1;
    {alu_negative, alu_zero, alu_carry, alu_overflow} = 4'b0110;
    br_valid = 1'b1; br_kind = 2'd0;
    @(posedge clk); #1;
    chk("pre_rst_done", {3'b0, br_done}, 4'd1);
    chk("pre_rst_flags", flags, 4'b0110);
    drive_idle();
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_done", {3'b0, br_done}, 4'd0);
    chk("mid_rst_taken", {3'b0, br_taken}, 4'd0);
    chk("mid_rst_flags", flags, 4'b0000);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_done", {3'b0, br_done}, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule : tb_branch_flag_unit
